toy_lsu_mem_port: RTL and testbench

//  Memory-side port directly downstream of the LSU mem request arbiter.
//  - Buffers LSU memory requests in a FIFO and forwards them to memory.
//  - Throttles outstanding reads to a fixed maximum.
//  - Registers memory read acks through one pipe stage back to the LSU load queue.
//  - Reports idle and protocol-error status.

---
 rtl/toy_lsu_mem_port_if.sv | 62 ++++++
 rtl/toy_lsu_mem_port.sv | 132 +++++++++++++
 tb/tb_toy_lsu_mem_port.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toy_lsu_mem_port_if.sv
// Bus bundle between the LSU arbiter, the memory, and the LSU load queue.
interface toy_lsu_mem_port_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned SB_WIDTH   = 10
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  s_mem_req_vld;
  logic                  s_mem_req_rdy;
  logic [ADDR_WIDTH-1:0] s_mem_req_addr;
  logic [DATA_WIDTH-1:0] s_mem_req_data;
  logic [STRB_WIDTH-1:0] s_mem_req_strb;
  logic                  s_mem_req_opcode;
  logic [SB_WIDTH-1:0]   s_mem_req_sb;

  logic                  m_mem_req_vld;
  logic                  m_mem_req_rdy;
  logic [ADDR_WIDTH-1:0] m_mem_req_addr;
  logic [DATA_WIDTH-1:0] m_mem_req_data;
  logic [STRB_WIDTH-1:0] m_mem_req_strb;
  logic                  m_mem_req_opcode;
  logic [SB_WIDTH-1:0]   m_mem_req_sb;

  logic                  mem_ack_vld;
  logic                  mem_ack_rdy;
  logic [DATA_WIDTH-1:0] mem_ack_data;
  logic [SB_WIDTH-1:0]   mem_ack_sb;

  logic                  lsu_ack_vld;
  logic                  lsu_ack_rdy;
  logic [DATA_WIDTH-1:0] lsu_ack_data;
  logic [SB_WIDTH-1:0]   lsu_ack_sb;

  // Port-block view
  modport slave (
    input  s_mem_req_vld, s_mem_req_addr, s_mem_req_data, s_mem_req_strb,
           s_mem_req_opcode, s_mem_req_sb,
    output s_mem_req_rdy,
    output m_mem_req_vld, m_mem_req_addr, m_mem_req_data, m_mem_req_strb,
           m_mem_req_opcode, m_mem_req_sb,
    input  m_mem_req_rdy,
    input  mem_ack_vld, mem_ack_data, mem_ack_sb,
    output mem_ack_rdy,
    output lsu_ack_vld, lsu_ack_data, lsu_ack_sb,
    input  lsu_ack_rdy
  );

  // Environment view (LSU arbiter, memory, load queue)
  modport master (
    output s_mem_req_vld, s_mem_req_addr, s_mem_req_data, s_mem_req_strb,
           s_mem_req_opcode, s_mem_req_sb,
    input  s_mem_req_rdy,
    input  m_mem_req_vld, m_mem_req_addr, m_mem_req_data, m_mem_req_strb,
           m_mem_req_opcode, m_mem_req_sb,
    output m_mem_req_rdy,
    output mem_ack_vld, mem_ack_data, mem_ack_sb,
    input  mem_ack_rdy,
    input  lsu_ack_vld, lsu_ack_data, lsu_ack_sb,
    output lsu_ack_rdy
  );
endinterface

// File: rtl/toy_lsu_mem_port.sv
// LSU memory-side port: in-order request FIFO, read-outstanding throttle,
// single-register read-ack stage back to the load queue.
module toy_lsu_mem_port #(
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned DATA_WIDTH         = 256,
  parameter int unsigned SB_WIDTH           = 10,
  parameter int unsigned REQ_DEPTH          = 4,
  parameter int unsigned MAX_RD_OUTSTANDING = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  toy_lsu_mem_port_if.slave                        bus,
  output logic [$clog2(MAX_RD_OUTSTANDING+1)-1:0]  rd_outstanding,
  output logic                                     idle,
  output logic                                     err_ack_underflow
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PTR_W      = $clog2(REQ_DEPTH);
  localparam int unsigned FCNT_W     = $clog2(REQ_DEPTH + 1);
  localparam int unsigned RCNT_W     = $clog2(MAX_RD_OUTSTANDING + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    logic                  opcode;
    logic [SB_WIDTH-1:0]   sb;
  } req_t;

  req_t                  r_mem [REQ_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [FCNT_W-1:0]     r_count;
  logic [RCNT_W-1:0]     r_rd_out;
  logic                  r_err;
  logic                  r_lsu_ack_vld;
  logic [DATA_WIDTH-1:0] r_lsu_ack_data;
  logic [SB_WIDTH-1:0]   r_lsu_ack_sb;

  req_t w_in;
  req_t w_head;
  logic w_empty;
  logic w_s_rdy;
  logic w_m_vld;
  logic w_push;
  logic w_pop;
  logic w_rd_issue;
  logic w_ack_rdy;
  logic w_mem_fire;
  logic w_lsu_fire;

  // Handshake and throttle decode
  always_comb begin
    w_in       = '{addr:   bus.s_mem_req_addr,
                   data:   bus.s_mem_req_data,
                   strb:   bus.s_mem_req_strb,
                   opcode: bus.s_mem_req_opcode,
                   sb:     bus.s_mem_req_sb};
    w_head     = r_mem[r_rd_ptr];
    w_empty    = (r_count == '0);
    w_s_rdy    = (r_count != FCNT_W'(REQ_DEPTH));
    w_m_vld    = !w_empty & (w_head.opcode | (r_rd_out < RCNT_W'(MAX_RD_OUTSTANDING)));
    w_push     = bus.s_mem_req_vld & w_s_rdy;
    w_pop      = w_m_vld & bus.m_mem_req_rdy;
    w_rd_issue = w_pop & !w_head.opcode;
    w_ack_rdy  = !r_lsu_ack_vld | bus.lsu_ack_rdy;
    w_mem_fire = bus.mem_ack_vld & w_ack_rdy;
    w_lsu_fire = r_lsu_ack_vld & bus.lsu_ack_rdy;
  end

  // FIFO storage; payload is don't-care until written, so it has no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + FCNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - FCNT_W'(1);
    end
  end

  // Live read count and sticky underflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_out <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_rd_issue && !w_lsu_fire)                      r_rd_out <= r_rd_out + RCNT_W'(1);
      else if (!w_rd_issue && w_lsu_fire && r_rd_out != '0) r_rd_out <= r_rd_out - RCNT_W'(1);
      if (w_lsu_fire && r_rd_out == '0) r_err <= 1'b1;
    end
  end

  // Ack valid: set on memory ack, cleared when the LSU takes it with nothing new behind
  always_ff @(posedge clk) begin
    if (rst)             r_lsu_ack_vld <= 1'b0;
    else if (w_mem_fire) r_lsu_ack_vld <= 1'b1;
    else if (w_lsu_fire) r_lsu_ack_vld <= 1'b0;
  end

  // Ack payload, held while the LSU stalls
  always_ff @(posedge clk) begin
    if (w_mem_fire) begin
      r_lsu_ack_data <= bus.mem_ack_data;
      r_lsu_ack_sb   <= bus.mem_ack_sb;
    end
  end

  assign bus.s_mem_req_rdy    = w_s_rdy;
  assign bus.m_mem_req_vld    = w_m_vld;
  assign bus.m_mem_req_addr   = w_head.addr;
  assign bus.m_mem_req_data   = w_head.data;
  assign bus.m_mem_req_strb   = w_head.strb;
  assign bus.m_mem_req_opcode = w_head.opcode;
  assign bus.m_mem_req_sb     = w_head.sb;
  assign bus.mem_ack_rdy      = w_ack_rdy;
  assign bus.lsu_ack_vld      = r_lsu_ack_vld;
  assign bus.lsu_ack_data     = r_lsu_ack_data;
  assign bus.lsu_ack_sb       = r_lsu_ack_sb;

  assign rd_outstanding    = r_rd_out;
  assign err_ack_underflow = r_err;
  assign idle              = w_empty & (r_rd_out == '0) & !r_lsu_ack_vld;
endmodule

// File: tb/tb_toy_lsu_mem_port.sv
// Bench for toy_lsu_mem_port: directed scenarios plus a randomized run
// checked against a queue-based model of the port.
module tb_toy_lsu_mem_port;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 256;
  localparam int unsigned SBW = 10;
  localparam int unsigned SW  = DW / 8;
  localparam int          MAX = 8;
  localparam int          DEP = 4;

  logic       clk;
  logic       rst;
  logic [3:0] rd_outstanding;
  logic       idle;
  logic       err_ack_underflow;

  int n_err = 0;
  int n_chk = 0;

  toy_lsu_mem_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SB_WIDTH(SBW)) bus ();

  toy_lsu_mem_port #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SB_WIDTH(SBW),
    .REQ_DEPTH(DEP), .MAX_RD_OUTSTANDING(MAX)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rd_outstanding(rd_outstanding), .idle(idle), .err_ack_underflow(err_ack_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic [SW-1:0]  strb;
    logic           op;
    logic [SBW-1:0] sb;
  } req_s;

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted (bounded)
  task automatic push(input logic [AW-1:0] a, input logic op, input logic [SW-1:0] s);
    int n;
    bus.s_mem_req_vld    = 1'b1;
    bus.s_mem_req_addr   = a;
    bus.s_mem_req_data   = rand_data();
    bus.s_mem_req_strb   = s;
    bus.s_mem_req_opcode = op;
    bus.s_mem_req_sb     = SBW'($urandom);
    #1;
    n = 0;
    while (!bus.s_mem_req_rdy && n < 50) begin tick(); n++; end
    n_chk++;
    if (bus.s_mem_req_rdy !== 1'b1) begin
      n_err++; $display("FAIL push_accept_timeout addr=%0h rdy=%0b required=1", a, bus.s_mem_req_rdy);
    end
    tick();
    bus.s_mem_req_vld = 1'b0;
  endtask

  // Memory returns n read acks back-to-back with the LSU always ready
  task automatic drain(input int n);
    bus.lsu_ack_rdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.mem_ack_vld  = 1'b1;
      bus.mem_ack_data = rand_data();
      bus.mem_ack_sb   = SBW'($urandom);
      tick();
    end
    bus.mem_ack_vld = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++; if (bus.s_mem_req_rdy !== 1'b1) begin n_err++; $display("FAIL rst_s_rdy got=%0b required=1", bus.s_mem_req_rdy); end
    n_chk++; if (bus.m_mem_req_vld !== 1'b0) begin n_err++; $display("FAIL rst_m_vld got=%0b required=0", bus.m_mem_req_vld); end
    n_chk++; if (bus.mem_ack_rdy !== 1'b1) begin n_err++; $display("FAIL rst_ack_rdy got=%0b required=1", bus.mem_ack_rdy); end
    n_chk++; if (bus.lsu_ack_vld !== 1'b0) begin n_err++; $display("FAIL rst_lsu_vld got=%0b required=0", bus.lsu_ack_vld); end
    n_chk++; if (idle !== 1'b1) begin n_err++; $display("FAIL rst_idle got=%0b required=1", idle); end
    n_chk++; if (rd_outstanding !== 4'd0) begin n_err++; $display("FAIL rst_rd_out got=%0d required=0", rd_outstanding); end
    n_chk++; if (err_ack_underflow !== 1'b0) begin n_err++; $display("FAIL rst_err got=%0b required=0", err_ack_underflow); end
  endtask

  task automatic test_fifo_fill();
    logic [SW-1:0] st [4];
    bus.m_mem_req_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st[i] = SW'($urandom);
      push(AW'(32'h2000 + i * 64), 1'b1, st[i]);
    end
    #1;
    n_chk++; if (bus.s_mem_req_rdy !== 1'b0) begin n_err++; $display("FAIL fill_full_rdy got=%0b required=0", bus.s_mem_req_rdy); end
    bus.m_mem_req_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if (bus.m_mem_req_vld !== 1'b1) begin n_err++; $display("FAIL fill_out_vld[%0d] got=%0b required=1", i, bus.m_mem_req_vld); end
      n_chk++; if (bus.m_mem_req_addr !== AW'(32'h2000 + i * 64)) begin n_err++; $display("FAIL fill_out_addr[%0d] got=%0h required=%0h", i, bus.m_mem_req_addr, 32'h2000 + i * 64); end
      n_chk++; if (bus.m_mem_req_strb !== st[i]) begin n_err++; $display("FAIL fill_out_strb[%0d] got=%0h required=%0h", i, bus.m_mem_req_strb, st[i]); end
      n_chk++; if (bus.m_mem_req_opcode !== 1'b1) begin n_err++; $display("FAIL fill_out_op[%0d] got=%0b required=1", i, bus.m_mem_req_opcode); end
      if (i == 0) begin
        n_chk++; if (bus.s_mem_req_rdy !== 1'b0) begin n_err++; $display("FAIL fill_pop_no_rdy got=%0b required=0", bus.s_mem_req_rdy); end
      end
      tick();
    end
    #1;
    n_chk++; if (bus.m_mem_req_vld !== 1'b0) begin n_err++; $display("FAIL fill_empty_vld got=%0b required=0", bus.m_mem_req_vld); end
    n_chk++; if (idle !== 1'b1) begin n_err++; $display("FAIL fill_idle got=%0b required=1", idle); end
  endtask

  task automatic test_read_throttle();
    bus.m_mem_req_rdy = 1'b1;
    bus.lsu_ack_rdy   = 1'b1;
    for (int i = 0; i < 9; i++) push(AW'(32'h1000 + i * 32), 1'b0, '1);
    tick();
    #1;
    n_chk++; if (rd_outstanding !== 4'd8) begin n_err++; $display("FAIL thr_rd_out got=%0d required=8", rd_outstanding); end
    n_chk++; if (bus.m_mem_req_vld !== 1'b0) begin n_err++; $display("FAIL thr_blocked_vld got=%0b required=0", bus.m_mem_req_vld); end
    n_chk++; if (bus.m_mem_req_addr !== AW'(32'h1100)) begin n_err++; $display("FAIL thr_head_addr got=%0h required=1100", bus.m_mem_req_addr); end
    bus.mem_ack_vld  = 1'b1;
    bus.mem_ack_data = rand_data();
    bus.mem_ack_sb   = SBW'($urandom);
    tick();
    bus.mem_ack_vld = 1'b0;
    #1;
    n_chk++; if (bus.lsu_ack_vld !== 1'b1) begin n_err++; $display("FAIL thr_ack_vld got=%0b required=1", bus.lsu_ack_vld); end
    n_chk++; if (bus.m_mem_req_vld !== 1'b0) begin n_err++; $display("FAIL thr_still_blocked got=%0b required=0", bus.m_mem_req_vld); end
    tick();
    #1;
    n_chk++; if (rd_outstanding !== 4'd7) begin n_err++; $display("FAIL thr_rd_out_dec got=%0d required=7", rd_outstanding); end
    n_chk++; if (bus.m_mem_req_vld !== 1'b1) begin n_err++; $display("FAIL thr_release_vld got=%0b required=1", bus.m_mem_req_vld); end
    tick();
    #1;
    n_chk++; if (rd_outstanding !== 4'd8) begin n_err++; $display("FAIL thr_rd_out_reissue got=%0d required=8", rd_outstanding); end
    n_chk++; if (bus.m_mem_req_vld !== 1'b0) begin n_err++; $display("FAIL thr_after_vld got=%0b required=0", bus.m_mem_req_vld); end
    drain(8);
    #1;
    n_chk++; if (rd_outstanding !== 4'd0) begin n_err++; $display("FAIL thr_drained got=%0d required=0", rd_outstanding); end
    n_chk++; if (idle !== 1'b1) begin n_err++; $display("FAIL thr_idle got=%0b required=1", idle); end
  endtask

  task automatic test_write_behind_read();
    bus.m_mem_req_rdy = 1'b1;
    for (int i = 0; i < 8; i++) push(AW'(32'h3000 + i * 32), 1'b0, '1);
    push(AW'(32'h4000), 1'b0, '1);
    push(AW'(32'h5000), 1'b1, SW'(32'h0000_00ff));
    tick();
    tick();
    #1;
    n_chk++; if (bus.m_mem_req_vld !== 1'b0) begin n_err++; $display("FAIL wbr_blocked got=%0b required=0", bus.m_mem_req_vld); end
    n_chk++; if (bus.m_mem_req_opcode !== 1'b0) begin n_err++; $display("FAIL wbr_head_op got=%0b required=0", bus.m_mem_req_opcode); end
    bus.mem_ack_vld  = 1'b1;
    bus.mem_ack_data = rand_data();
    tick();
    bus.mem_ack_vld = 1'b0;
    #1;
    n_chk++; if (bus.m_mem_req_vld !== 1'b0) begin n_err++; $display("FAIL wbr_write_held got=%0b required=0", bus.m_mem_req_vld); end
    tick();
    #1;
    n_chk++; if (bus.m_mem_req_vld !== 1'b1 || bus.m_mem_req_addr !== AW'(32'h4000)) begin n_err++; $display("FAIL wbr_read_out vld=%0b addr=%0h required vld=1 addr=4000", bus.m_mem_req_vld, bus.m_mem_req_addr); end
    tick();
    #1;
    n_chk++; if (bus.m_mem_req_vld !== 1'b1 || bus.m_mem_req_addr !== AW'(32'h5000) || bus.m_mem_req_opcode !== 1'b1) begin n_err++; $display("FAIL wbr_write_out vld=%0b addr=%0h op=%0b required vld=1 addr=5000 op=1", bus.m_mem_req_vld, bus.m_mem_req_addr, bus.m_mem_req_opcode); end
    tick();
    #1;
    n_chk++; if (rd_outstanding !== 4'd8) begin n_err++; $display("FAIL wbr_rd_out got=%0d required=8", rd_outstanding); end
    drain(8);
  endtask

  task automatic test_ack_stall();
    logic [DW-1:0]  d1;
    logic [DW-1:0]  d2;
    logic [SBW-1:0] s2;
    bus.m_mem_req_rdy = 1'b1;
    push(AW'(32'h6000), 1'b0, '1);
    push(AW'(32'h6020), 1'b0, '1);
    tick();
    tick();
    d1 = rand_data();
    d2 = rand_data();
    s2 = SBW'($urandom);
    bus.lsu_ack_rdy  = 1'b0;
    bus.mem_ack_vld  = 1'b1;
    bus.mem_ack_data = d1;
    bus.mem_ack_sb   = 10'h380;
    #1;
    n_chk++; if (bus.mem_ack_rdy !== 1'b1) begin n_err++; $display("FAIL stall_first_rdy got=%0b required=1", bus.mem_ack_rdy); end
    tick();
    bus.mem_ack_data = d2;
    bus.mem_ack_sb   = s2;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_chk++; if (bus.mem_ack_rdy !== 1'b0) begin n_err++; $display("FAIL stall_ack_rdy[%0d] got=%0b required=0", k, bus.mem_ack_rdy); end
      n_chk++; if (bus.lsu_ack_vld !== 1'b1 || bus.lsu_ack_data !== d1 || bus.lsu_ack_sb !== 10'h380) begin n_err++; $display("FAIL stall_hold[%0d] vld=%0b sb=%0h required vld=1 sb=380 data_ok=%0b", k, bus.lsu_ack_vld, bus.lsu_ack_sb, bus.lsu_ack_data === d1); end
      if (k < 3) tick();
    end
    bus.lsu_ack_rdy = 1'b1;
    #1;
    n_chk++; if (bus.mem_ack_rdy !== 1'b1) begin n_err++; $display("FAIL stall_release_rdy got=%0b required=1", bus.mem_ack_rdy); end
    tick();
    bus.mem_ack_vld = 1'b0;
    #1;
    n_chk++; if (bus.lsu_ack_vld !== 1'b1 || bus.lsu_ack_data !== d2 || bus.lsu_ack_sb !== s2) begin n_err++; $display("FAIL stall_second vld=%0b sb=%0h required vld=1 sb=%0h data_ok=%0b", bus.lsu_ack_vld, bus.lsu_ack_sb, s2, bus.lsu_ack_data === d2); end
    tick();
    #1;
    n_chk++; if (bus.lsu_ack_vld !== 1'b0) begin n_err++; $display("FAIL stall_done_vld got=%0b required=0", bus.lsu_ack_vld); end
    n_chk++; if (rd_outstanding !== 4'd0) begin n_err++; $display("FAIL stall_rd_out got=%0d required=0", rd_outstanding); end
  endtask

  task automatic test_same_cycle_and_underflow();
    bus.m_mem_req_rdy = 1'b1;
    bus.lsu_ack_rdy   = 1'b1;
    for (int i = 0; i < 3; i++) push(AW'(32'h7000 + i * 32), 1'b0, '1);
    tick();
    #1;
    n_chk++; if (rd_outstanding !== 4'd3) begin n_err++; $display("FAIL sc_setup got=%0d required=3", rd_outstanding); end
    bus.m_mem_req_rdy = 1'b0;
    push(AW'(32'h7100), 1'b0, '1);
    bus.mem_ack_vld  = 1'b1;
    bus.mem_ack_data = rand_data();
    tick();
    bus.mem_ack_vld   = 1'b0;
    bus.m_mem_req_rdy = 1'b1;
    #1;
    n_chk++; if (bus.lsu_ack_vld !== 1'b1 || bus.m_mem_req_vld !== 1'b1) begin n_err++; $display("FAIL sc_both_fire lsu_vld=%0b m_vld=%0b required 1 1", bus.lsu_ack_vld, bus.m_mem_req_vld); end
    tick();
    #1;
    n_chk++; if (rd_outstanding !== 4'd3) begin n_err++; $display("FAIL sc_unchanged got=%0d required=3", rd_outstanding); end
    drain(3);
    #1;
    n_chk++; if (rd_outstanding !== 4'd0 || err_ack_underflow !== 1'b0) begin n_err++; $display("FAIL sc_drained rd_out=%0d err=%0b required 0 0", rd_outstanding, err_ack_underflow); end
    bus.mem_ack_vld = 1'b1;
    tick();
    bus.mem_ack_vld = 1'b0;
    tick();
    #1;
    n_chk++; if (err_ack_underflow !== 1'b1) begin n_err++; $display("FAIL uf_flag got=%0b required=1", err_ack_underflow); end
    n_chk++; if (rd_outstanding !== 4'd0) begin n_err++; $display("FAIL uf_rd_out got=%0d required=0", rd_outstanding); end
    tick();
    #1;
    n_chk++; if (err_ack_underflow !== 1'b1) begin n_err++; $display("FAIL uf_sticky got=%0b required=1", err_ack_underflow); end
  endtask

  task automatic test_reset_mid_op();
    bus.m_mem_req_rdy = 1'b0;
    for (int i = 0; i < 3; i++) push(AW'(32'h8000 + i * 32), 1'b1, '1);
    bus.lsu_ack_rdy = 1'b0;
    bus.mem_ack_vld = 1'b1;
    tick();
    bus.mem_ack_vld = 1'b0;
    #1;
    n_chk++; if (bus.lsu_ack_vld !== 1'b1 || bus.m_mem_req_vld !== 1'b1 || idle !== 1'b0) begin n_err++; $display("FAIL mid_setup lsu_vld=%0b m_vld=%0b idle=%0b required 1 1 0", bus.lsu_ack_vld, bus.m_mem_req_vld, idle); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_chk++; if (idle !== 1'b1) begin n_err++; $display("FAIL mid_idle got=%0b required=1", idle); end
    n_chk++; if (bus.m_mem_req_vld !== 1'b0) begin n_err++; $display("FAIL mid_m_vld got=%0b required=0", bus.m_mem_req_vld); end
    n_chk++; if (bus.lsu_ack_vld !== 1'b0) begin n_err++; $display("FAIL mid_lsu_vld got=%0b required=0", bus.lsu_ack_vld); end
    n_chk++; if (err_ack_underflow !== 1'b0) begin n_err++; $display("FAIL mid_err got=%0b required=0", err_ack_underflow); end
    n_chk++; if (bus.s_mem_req_rdy !== 1'b1) begin n_err++; $display("FAIL mid_s_rdy got=%0b required=1", bus.s_mem_req_rdy); end
    bus.m_mem_req_rdy = 1'b1;
    bus.lsu_ack_rdy   = 1'b1;
    tick();
    tick();
    #1;
    n_chk++; if (bus.m_mem_req_vld !== 1'b0 || idle !== 1'b1) begin n_err++; $display("FAIL mid_no_replay m_vld=%0b idle=%0b required 0 1", bus.m_mem_req_vld, idle); end
  endtask

  // Random traffic against a queue model of the port
  task automatic test_random();
    req_s          q[$];
    req_s          nr;
    int            outst;
    int            pend;
    bit            lv;
    logic [DW-1:0] ld;
    logic [SBW-1:0] ls;
    bit e_srdy, e_mvld, e_ardy, e_idle, psh, pop, mf, lf;
    do_reset();
    outst = 0; pend = 0; lv = 1'b0; ld = '0; ls = '0;
    for (int c = 0; c < 1500; c++) begin
      nr.addr = AW'($urandom);
      nr.data = rand_data();
      nr.strb = SW'($urandom);
      nr.op   = ($urandom_range(0, 2) == 0);
      nr.sb   = SBW'($urandom);
      bus.s_mem_req_vld    = ($urandom_range(0, 2) != 0);
      bus.s_mem_req_addr   = nr.addr;
      bus.s_mem_req_data   = nr.data;
      bus.s_mem_req_strb   = nr.strb;
      bus.s_mem_req_opcode = nr.op;
      bus.s_mem_req_sb     = nr.sb;
      bus.m_mem_req_rdy    = ($urandom_range(0, 3) != 0);
      bus.lsu_ack_rdy      = ($urandom_range(0, 3) != 0);
      bus.mem_ack_vld      = (pend > 0) && ($urandom_range(0, 3) == 0);
      bus.mem_ack_data     = rand_data();
      bus.mem_ack_sb       = SBW'($urandom);
      #1;
      e_srdy = (q.size() < DEP);
      e_mvld = (q.size() > 0) && (q[0].op || outst < MAX);
      e_ardy = !lv || bus.lsu_ack_rdy;
      e_idle = (q.size() == 0) && (outst == 0) && !lv;
      n_chk++; if (bus.s_mem_req_rdy !== e_srdy) begin n_err++; $display("FAIL rnd_s_rdy c=%0d got=%0b required=%0b", c, bus.s_mem_req_rdy, e_srdy); end
      n_chk++; if (bus.m_mem_req_vld !== e_mvld) begin n_err++; $display("FAIL rnd_m_vld c=%0d got=%0b required=%0b", c, bus.m_mem_req_vld, e_mvld); end
      if (e_mvld) begin
        n_chk++; if (bus.m_mem_req_addr !== q[0].addr || bus.m_mem_req_data !== q[0].data || bus.m_mem_req_strb !== q[0].strb || bus.m_mem_req_opcode !== q[0].op || bus.m_mem_req_sb !== q[0].sb) begin n_err++; $display("FAIL rnd_m_head c=%0d addr=%0h op=%0b sb=%0h required addr=%0h op=%0b sb=%0h", c, bus.m_mem_req_addr, bus.m_mem_req_opcode, bus.m_mem_req_sb, q[0].addr, q[0].op, q[0].sb); end
      end
      n_chk++; if (bus.mem_ack_rdy !== e_ardy) begin n_err++; $display("FAIL rnd_ack_rdy c=%0d got=%0b required=%0b", c, bus.mem_ack_rdy, e_ardy); end
      n_chk++; if (bus.lsu_ack_vld !== lv) begin n_err++; $display("FAIL rnd_lsu_vld c=%0d got=%0b required=%0b", c, bus.lsu_ack_vld, lv); end
      if (lv) begin
        n_chk++; if (bus.lsu_ack_data !== ld || bus.lsu_ack_sb !== ls) begin n_err++; $display("FAIL rnd_lsu_payload c=%0d sb=%0h required sb=%0h data_ok=%0b", c, bus.lsu_ack_sb, ls, bus.lsu_ack_data === ld); end
      end
      n_chk++; if (rd_outstanding !== 4'(outst)) begin n_err++; $display("FAIL rnd_rd_out c=%0d got=%0d required=%0d", c, rd_outstanding, outst); end
      n_chk++; if (idle !== e_idle || err_ack_underflow !== 1'b0) begin n_err++; $display("FAIL rnd_status c=%0d idle=%0b err=%0b required idle=%0b err=0", c, idle, err_ack_underflow, e_idle); end
      psh = bus.s_mem_req_vld && e_srdy;
      pop = e_mvld && bus.m_mem_req_rdy;
      mf  = bus.mem_ack_vld && e_ardy;
      lf  = lv && bus.lsu_ack_rdy;
      if (pop) begin
        if (!q[0].op) begin outst++; pend++; end
        void'(q.pop_front());
      end
      if (psh) q.push_back(nr);
      if (lf) outst--;
      if (mf) begin pend--; lv = 1'b1; ld = bus.mem_ack_data; ls = bus.mem_ack_sb; end
      else if (lf) lv = 1'b0;
      tick();
    end
    bus.s_mem_req_vld = 1'b0;
    bus.mem_ack_vld   = 1'b0;
  endtask

  initial begin
    rst                  = 1'b1;
    bus.s_mem_req_vld    = 1'b0;
    bus.s_mem_req_addr   = '0;
    bus.s_mem_req_data   = '0;
    bus.s_mem_req_strb   = '0;
    bus.s_mem_req_opcode = 1'b0;
    bus.s_mem_req_sb     = '0;
    bus.m_mem_req_rdy    = 1'b0;
    bus.mem_ack_vld      = 1'b0;
    bus.mem_ack_data     = '0;
    bus.mem_ack_sb       = '0;
    bus.lsu_ack_rdy      = 1'b0;
    test_reset();
    test_fifo_fill();
    test_read_throttle();
    test_write_behind_read();
    test_ack_stall();
    test_same_cycle_and_underflow();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
